// File: rtl/serial_tx_fifo.sv
// Byte FIFO between the core's MMIO serial data register and the serial transmitter.
// Absorbs bursts of core writes and drains one byte per transmitter frame.
module serial_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [7:0]       tx_data,
    output logic             tx_data_available,
    input  logic             tx_ready,
    output logic [PTR_W:0]   level,
    output logic             full,
    output logic             empty,
    output logic             idle,
    output logic             overflow
);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_level;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;

    assign full              = (r_level == FULL_LEVEL);
    assign empty             = (r_level == '0);
    assign in_ready          = !full;
    assign tx_data_available = !empty;
    assign w_push            = in_valid && in_ready;
    assign w_pop             = tx_data_available && tx_ready;
    assign tx_data           = r_mem[r_rptr];
    assign level             = r_level;
    assign overflow          = r_overflow;
    assign idle              = empty && tx_ready;

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
            // Flush wins over any same-cycle push or pop; overflow survives it.
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + (PTR_W + 1)'(1);
                    2'b01:   r_level <= r_level - (PTR_W + 1)'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed self-checking bench for serial_tx_fifo with a simple frame-timed transmitter model.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_serial_tx_fifo;
    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_data_available;
    logic       tx_ready;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       idle;
    logic       overflow;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    serial_tx_fifo #(.DEPTH(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .tx_data           (tx_data),
        .tx_data_available (tx_data_available),
        .tx_ready          (tx_ready),
        .level             (level),
        .full              (full),
        .empty             (empty),
        .idle              (idle),
        .overflow          (overflow)
    );

    always #5 clock = ~clock;

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given upstream write request, then the request is dropped.
    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        in_valid = valid;
        in_data  = data;
        stepCycle();
        in_valid = 1'b0;
    endtask

    // Transmitter model: captures on a pop edge, then stays busy for frameLen cycles.
    task automatic drainExpect(input string tag, input int n, input logic [7:0] firstByte, input int frameLen);
        int got    = 0;
        int cycles = 0;
        int busy   = 0;
        logic [7:0] expByte;
        tx_ready = 1'b1;
        while (got < n && cycles < 2000) begin
            if (tx_ready && tx_data_available) begin
                expByte = firstByte + 8'(got);
                checkOutput(tag, tx_data, expByte);
                got++;
                stepCycle();
                tx_ready = 1'b0;
                busy = frameLen;
            end else begin
                stepCycle();
                if (busy > 0) begin
                    busy--;
                    if (busy == 0) tx_ready = 1'b1;
                end
            end
            cycles++;
        end
        checkOutput({tag, "_count"}, got, n);
        while (busy > 0) begin
            stepCycle();
            busy--;
        end
        tx_ready = 1'b1;
        #1;
    endtask

    initial begin
        int seenAvail;
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tx_ready = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        checkOutput("rst_level", level, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_avail", tx_data_available, 0);
        checkOutput("rst_overflow", overflow, 0);

        // Single byte: visible one cycle after the push, popped on the next edge.
        tx_ready = 1'b1;
        applyStimulus(1'b1, 8'h41);
        checkOutput("t1_tx_data", tx_data, 8'h41);
        checkOutput("t1_avail", tx_data_available, 1);
        checkOutput("t1_level", level, 1);
        stepCycle();
        tx_ready = 1'b0;
        #1;
        checkOutput("t1_level_after_pop", level, 0);
        checkOutput("t1_empty_after_pop", empty, 1);
        checkOutput("t1_idle_busy", idle, 0);
        tx_ready = 1'b1;
        #1;
        checkOutput("t1_idle", idle, 1);

        // Fill to full, overflow on a 17th push, then drain in order.
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("t2_level_full", level, 16);
        checkOutput("t2_full", full, 1);
        checkOutput("t2_in_ready", in_ready, 0);
        checkOutput("t2_overflow_before", overflow, 0);
        applyStimulus(1'b1, 8'hFF);
        checkOutput("t2_level_after_drop", level, 16);
        checkOutput("t2_overflow", overflow, 1);
        drainExpect("t2_drain", 16, 8'h00, 10);
        checkOutput("t2_empty_end", empty, 1);
        checkOutput("t2_avail_end", tx_data_available, 0);
        checkOutput("t2_overflow_sticky", overflow, 1);
        checkOutput("t2_idle_end", idle, 1);

        // Three rounds of 12 to carry both pointers across the wrap.
        for (int r = 0; r < 3; r++) begin
            tx_ready = 1'b0;
            for (int k = 0; k < 12; k++) applyStimulus(1'b1, 8'(8'h50 + r * 12 + k));
            checkOutput("t3_level_12", level, 12);
            drainExpect("t3_drain", 12, 8'(8'h50 + r * 12), 2);
        end
        checkOutput("t3_level_end", level, 0);

        // Simultaneous push and pop at level 5, then a refused push at full.
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'(8'hA0 + k));
        checkOutput("t4_level5", level, 5);
        checkOutput("t4_head", tx_data, 8'hA0);
        tx_ready = 1'b1;
        applyStimulus(1'b1, 8'hA5);
        tx_ready = 1'b0;
        #1;
        checkOutput("t4_level_same", level, 5);
        checkOutput("t4_head_next", tx_data, 8'hA1);
        for (int k = 0; k < 11; k++) applyStimulus(1'b1, 8'(8'hA6 + k));
        checkOutput("t4_level16", level, 16);
        in_valid = 1'b1;
        in_data  = 8'hB1;
        tx_ready = 1'b1;
        stepCycle();
        tx_ready = 1'b0;
        #1;
        checkOutput("t4_refused_level", level, 15);
        checkOutput("t4_in_ready_freed", in_ready, 1);
        stepCycle();
        in_valid = 1'b0;
        checkOutput("t4_accepted_level", level, 16);
        drainExpect("t4_drain", 16, 8'hA2, 1);
        checkOutput("t4_level_end", level, 0);

        // Flush after the first byte is captured, with a push in the flush cycle.
        tx_ready = 1'b0;
        applyStimulus(1'b1, 8'h10);
        applyStimulus(1'b1, 8'h20);
        applyStimulus(1'b1, 8'h30);
        checkOutput("t5_level3", level, 3);
        checkOutput("t5_head", tx_data, 8'h10);
        tx_ready = 1'b1;
        stepCycle();
        tx_ready = 1'b0;
        flush    = 1'b1;
        applyStimulus(1'b1, 8'h40);
        flush = 1'b0;
        checkOutput("t5_level_flushed", level, 0);
        checkOutput("t5_empty_flushed", empty, 1);
        checkOutput("t5_overflow_kept", overflow, 1);
        seenAvail = 0;
        for (int c = 0; c < 9; c++) begin
            if (tx_data_available) seenAvail++;
            stepCycle();
        end
        checkOutput("t5_no_more_bytes", seenAvail, 0);
        tx_ready = 1'b1;
        #1;
        checkOutput("t5_idle", idle, 1);

        // Reset in the middle of a queued stream.
        tx_ready = 1'b0;
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 8'(8'hC0 + k));
        checkOutput("t6_level7", level, 7);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("t6_level", level, 0);
        checkOutput("t6_in_ready", in_ready, 1);
        checkOutput("t6_overflow", overflow, 0);
        checkOutput("t6_avail", tx_data_available, 0);
        tx_ready = 1'b0;
        applyStimulus(1'b1, 8'h77);
        checkOutput("t6_post_reset_head", tx_data, 8'h77);
        checkOutput("t6_post_reset_level", level, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
Byte FIFO between the core's memory-mapped serial data register and the serial transmitter. It absorbs bursts of core byte writes so an MMIO write completes in one cycle unless the FIFO is full. It drains to the transmitter one byte per frame and exposes occupancy and idle status for a readable MMIO status register.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two and at least 2.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clock  input  1  core clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous clear of all queued bytes; active-high.
in_valid  input  1  upstream byte write request.
in_data  input  8  byte to enqueue.
in_ready  output  1  FIFO can accept; equals !full.
tx_data  output  8  head byte presented to the transmitter.
tx_data_available  output  1  head valid; equals !empty.
tx_ready  input  1  transmitter idle and able to capture.
level  output  PTR_W+1  current entry count, 0..DEPTH.
full  output  1  level == DEPTH.
empty  output  1  level == 0.
idle  output  1  empty && tx_ready; every queued byte has left the line.
overflow  output  1  sticky; set by a push attempt while full.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. Ports are named clock and reset.
- Storage: DEPTH x 8 register array, read pointer and write pointer of PTR_W bits each, and a PTR_W+1 count. Pointers wrap modulo DEPTH by natural overflow.
- Reset values: level=0, empty=1, full=0, in_ready=1, tx_data_available=0, overflow=0, both pointers=0. tx_data is don't-care while empty; the bench must not check it then.
- Push: occurs on a rising edge where in_valid && in_ready. mem[wptr]<=in_data, wptr++.
- Push while full: in_valid && !in_ready is ignored and sets overflow. overflow clears only on reset.
- Pop: occurs on a rising edge where tx_data_available && tx_ready. The transmitter captures tx_data on that same edge and deasserts tx_ready from the next cycle until its frame completes. rptr++.
- tx_data = mem[rptr], combinational from registered state. No input-to-output bypass: a byte pushed into an empty FIFO appears on tx_data with tx_data_available=1 one cycle after the push edge.
- Simultaneous push and pop: level unchanged, both pointers advance.
  - When full, in_ready=0, so a same-cycle pop does not admit a push. A slot frees one cycle later.
  - When empty, tx_data_available=0, so no pop occurs.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. full and empty are decoded from level.
- flush: pointers and level go to 0 on that edge. Any push or pop in the same cycle is discarded. overflow is not cleared. A byte already captured by the transmitter still completes its frame.
- Reset mid-frame: FIFO state clears as above. The transmitter is reset from the same reset.
- Upstream write-complete semantics for the MMIO decode: write_complete = in_valid && in_ready. The core stalls only while full.

Test Plan:
- Reset, then hold tx_ready=1 and push 0x41. Expect: cycle+1 tx_data=0x41, tx_data_available=1. Pop on that edge. Then level=0, empty=1. idle=1 once tx_ready returns.
- tx_ready=0, push 16 bytes 0x00..0x0F. Expect: level=16, full=1, in_ready=0. A 17th push (0xFF) is dropped and overflow=1. Release tx_ready with a 10-cycle frame model. Expect drained order 0x00..0x0F, and 0xFF is never emitted.
- Wrap-around: three rounds of 12 pushes and 12 pops (36 bytes, incrementing pattern). Expect exact order preserved across the pointer wrap and level=0 at the end.
- At level=5, push and pop on the same edge. Expect level stays 5 and head advances to the next byte. At level=16, assert in_valid during a pop. Expect that push refused that cycle and accepted the next cycle.
- Queue 0x10,0x20,0x30; after 0x10 is captured, assert flush. Expect level=0 and empty=1 next cycle, 0x20/0x30 never presented, overflow unchanged, and idle=1 after the 0x10 frame ends.
- Assert reset mid-stream with level=7. Expect next cycle level=0, in_ready=1, overflow=0, tx_data_available=0.
